// File: rtl/dmux_stream_pkg.sv
// Shared definitions for the stream demultiplexer: input routing modes.
// The reserved code 2'b11 is routed exactly like addressed mode.
package dmux_stream_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'b00,
    MODE_BCAST = 2'b01,
    MODE_RR    = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Next round-robin pointer for an nch-channel ring.
  function automatic int rr_next(input int cur, input int nch);
    return (cur >= nch - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/dmux_stream_chan_reg.sv
// One-entry valid/ready output register for a single demux channel.
// A load wins over a drain on the same edge, so a consumed entry can be
// refilled without a bubble.
module dmux_chan_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  input  logic             ready,
  output logic             free
);

  // Channel can take a new beat when empty or being drained this cycle.
  always_comb free = !valid || ready;

  // Holding register: load sets full, consume without load empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-NCH stream demultiplexer with addressed, broadcast and
// round-robin routing. Out-of-range addressed beats are accepted and dropped.
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH),
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [SELW-1:0]      rr_ptr,
  output logic [CNTW-1:0]      drop_cnt
);

  logic [NCH-1:0] free;
  logic [NCH-1:0] load;
  logic           sel_ok;
  logic           drop;
  logic           rr_adv;

  // Every select code is a real channel when NCH is a power of two.
  generate
    if (NCH == (1 << SELW)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = (int'(in_sel) < NCH);
    end
  endgenerate

  // Routing decode; in_ready depends only on mode/select/pointer/channel state.
  always_comb begin
    in_ready = 1'b0;
    load     = '0;
    drop     = 1'b0;
    rr_adv   = 1'b0;
    case (mode_e'(mode))
      MODE_BCAST: begin
        in_ready = &free;
        if (in_valid && (&free)) load = '1;
      end
      MODE_RR: begin
        in_ready = free[rr_ptr];
        if (in_valid && free[rr_ptr]) begin
          load[rr_ptr] = 1'b1;
          rr_adv       = 1'b1;
        end
      end
      default: begin
        if (sel_ok) begin
          in_ready = free[in_sel];
          if (in_valid && free[in_sel]) load[in_sel] = 1'b1;
        end else begin
          in_ready = 1'b1;
          drop     = in_valid;
        end
      end
    endcase
  end

  // Round-robin pointer moves only on a beat accepted in round-robin mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (rr_adv) begin
      rr_ptr <= SELW'(rr_next(int'(rr_ptr), NCH));
    end
  end

  // Saturating count of discarded out-of-range beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNTW{1'b1}})) begin
      drop_cnt <= drop_cnt + CNTW'(1);
    end
  end

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_chan
      dmux_chan_reg #(.WIDTH(WIDTH)) u_chan (
        .clk   (clk),
        .reset (reset),
        .load  (load[k]),
        .d     (in_data),
        .q     (out_data[k*WIDTH +: WIDTH]),
        .valid (out_valid[k]),
        .ready (out_ready[k]),
        .free  (free[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: a 4-channel instance driven from a vector table with
// a per-channel scoreboard, and a 3-channel instance for out-of-range drops.
module tb_dmux_stream;
  import dmux_stream_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  mode;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [7:0]  drop_cnt;

  logic [1:0]  mode3;
  logic [15:0] in_data3;
  logic [1:0]  in_sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [47:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [1:0]  rr_ptr3;
  logic [7:0]  drop_cnt3;

  dmux_stream #(.WIDTH(16), .NCH(4), .CNTW(8)) u4 (
    .clk(clk), .reset(reset), .mode(mode), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
  );

  dmux_stream #(.WIDTH(16), .NCH(3), .CNTW(8)) u3 (
    .clk(clk), .reset(reset), .mode(mode3), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .rr_ptr(rr_ptr3), .drop_cnt(drop_cnt3)
  );

  typedef struct {
    logic [1:0]  m;
    logic [1:0]  s;
    logic [15:0] d;
    logic        v;
    logic [3:0]  r;
    logic        erdy;
    logic [3:0]  eov;
    logic [1:0]  err;
  } vec_t;

  vec_t        tbl [29];
  logic [15:0] sbq [4][$];
  logic [15:0] mdata [4];
  logic [1:0]  brr;
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s,
                              input logic [15:0] d, input logic v, input logic [3:0] r,
                              input logic erdy, input logic [3:0] eov, input logic [1:0] err);
    vec_t t;
    t.m = m; t.s = s; t.d = d; t.v = v; t.r = r;
    t.erdy = erdy; t.eov = eov; t.err = err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int idx);
    logic [3:0]  tgt;
    logic [15:0] exp_d;
    mode = t.m; in_sel = t.s; in_data = t.d; in_valid = t.v; out_ready = t.r;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", idx), {63'd0, in_ready}, {63'd0, t.erdy});
    for (int k = 0; k < 4; k++) begin
      if (out_valid[k] && t.r[k]) begin
        if (sbq[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL v%0d sb_ch%0d: got beat %0h, expected none", idx, k, out_data[k*16 +: 16]);
        end else begin
          exp_d = sbq[k].pop_front();
          chk($sformatf("v%0d sb_ch%0d", idx, k), {48'd0, out_data[k*16 +: 16]}, {48'd0, exp_d});
        end
      end
    end
    tgt = '0;
    if (t.v && t.erdy) begin
      case (t.m)
        2'b01:   tgt = 4'b1111;
        2'b10: begin
          tgt[brr] = 1'b1;
          brr = brr + 2'd1;
        end
        default: tgt[t.s] = 1'b1;
      endcase
      for (int k = 0; k < 4; k++) begin
        if (tgt[k]) begin
          sbq[k].push_back(t.d);
          mdata[k] = t.d;
        end
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), {60'd0, out_valid}, {60'd0, t.eov});
    chk($sformatf("v%0d rr_ptr", idx), {62'd0, rr_ptr}, {62'd0, t.err});
    for (int k = 0; k < 4; k++) begin
      if (t.eov[k])
        chk($sformatf("v%0d data_ch%0d", idx, k), {48'd0, out_data[k*16 +: 16]}, {48'd0, mdata[k]});
    end
  endtask

  initial begin
    // addressed, backpressure, drain+refill
    tbl[0]  = mk(2'b00, 2'd2, 16'hBEEF, 1, 4'hF, 1, 4'b0100, 2'd0);
    tbl[1]  = mk(2'b00, 2'd0, 16'h0000, 0, 4'hF, 1, 4'b0000, 2'd0);
    tbl[2]  = mk(2'b00, 2'd1, 16'h1111, 1, 4'hD, 1, 4'b0010, 2'd0);
    tbl[3]  = mk(2'b00, 2'd1, 16'h2222, 1, 4'hD, 0, 4'b0010, 2'd0);
    tbl[4]  = mk(2'b00, 2'd1, 16'h2222, 1, 4'hF, 1, 4'b0010, 2'd0);
    tbl[5]  = mk(2'b00, 2'd0, 16'h0000, 0, 4'hF, 1, 4'b0000, 2'd0);
    // broadcast blocked by a stalled channel, then released
    tbl[6]  = mk(2'b00, 2'd3, 16'h3333, 1, 4'hF, 1, 4'b1000, 2'd0);
    tbl[7]  = mk(2'b01, 2'd0, 16'h1234, 1, 4'h7, 0, 4'b1000, 2'd0);
    tbl[8]  = mk(2'b01, 2'd0, 16'h1234, 1, 4'hF, 1, 4'b1111, 2'd0);
    tbl[9]  = mk(2'b00, 2'd0, 16'h0000, 0, 4'hF, 1, 4'b0000, 2'd0);
    // round-robin, six beats
    tbl[10] = mk(2'b10, 2'd0, 16'd0, 1, 4'hF, 1, 4'b0001, 2'd1);
    tbl[11] = mk(2'b10, 2'd0, 16'd1, 1, 4'hF, 1, 4'b0010, 2'd2);
    tbl[12] = mk(2'b10, 2'd0, 16'd2, 1, 4'hF, 1, 4'b0100, 2'd3);
    tbl[13] = mk(2'b10, 2'd0, 16'd3, 1, 4'hF, 1, 4'b1000, 2'd0);
    tbl[14] = mk(2'b10, 2'd0, 16'd4, 1, 4'hF, 1, 4'b0001, 2'd1);
    tbl[15] = mk(2'b10, 2'd0, 16'd5, 1, 4'hF, 1, 4'b0010, 2'd2);
    tbl[16] = mk(2'b00, 2'd0, 16'h0000, 0, 4'hF, 1, 4'b0000, 2'd2);
    // round-robin stalling on a held channel; pointer holds in addressed mode
    tbl[17] = mk(2'b00, 2'd0, 16'hAAAA, 1, 4'hF, 1, 4'b0001, 2'd2);
    tbl[18] = mk(2'b10, 2'd0, 16'd6, 1, 4'hE, 1, 4'b0101, 2'd3);
    tbl[19] = mk(2'b10, 2'd0, 16'd7, 1, 4'hE, 1, 4'b1001, 2'd0);
    tbl[20] = mk(2'b10, 2'd0, 16'd8, 1, 4'hE, 0, 4'b0001, 2'd0);
    tbl[21] = mk(2'b00, 2'd0, 16'h0000, 0, 4'hF, 1, 4'b0000, 2'd0);
    // reserved mode routes as addressed
    tbl[22] = mk(2'b11, 2'd1, 16'h5555, 1, 4'hF, 1, 4'b0010, 2'd0);
    tbl[23] = mk(2'b00, 2'd0, 16'h0000, 0, 4'hF, 1, 4'b0000, 2'd0);
    // burst interrupted by reset, then first beat after release
    tbl[24] = mk(2'b10, 2'd0, 16'h0010, 1, 4'h0, 1, 4'b0001, 2'd1);
    tbl[25] = mk(2'b10, 2'd0, 16'h0011, 1, 4'h0, 1, 4'b0011, 2'd2);
    tbl[26] = mk(2'b10, 2'd0, 16'h0012, 1, 4'h0, 1, 4'b0111, 2'd3);
    tbl[27] = mk(2'b00, 2'd0, 16'hC0DE, 1, 4'hF, 1, 4'b0001, 2'd0);
    tbl[28] = mk(2'b00, 2'd1, 16'h0000, 0, 4'hF, 1, 4'b0000, 2'd0);

    brr = 2'd0;
    for (int k = 0; k < 4; k++) mdata[k] = 16'h0;
    mode = 2'b00; in_sel = 2'd0; in_data = 16'h0; in_valid = 1'b0; out_ready = 4'hF;
    mode3 = 2'b00; in_sel3 = 2'd3; in_data3 = 16'h0; in_valid3 = 1'b0; out_ready3 = 3'b111;
    reset = 1'b1;
    #12;
    chk("reset out_valid", {60'd0, out_valid}, 64'd0);
    chk("reset out_data", out_data, 64'd0);
    chk("reset rr_ptr", {62'd0, rr_ptr}, 64'd0);
    chk("reset drop_cnt", {56'd0, drop_cnt}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) step(tbl[i], i);
    chk("sb_drained", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 64'd0);

    // out-of-range select on the 3-channel instance, past saturation
    in_valid3 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk($sformatf("drop%0d in_ready", i), {63'd0, in_ready3}, 64'd1);
      chk($sformatf("drop%0d out_valid", i), {61'd0, out_valid3}, 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("drop%0d drop_cnt", i), {56'd0, drop_cnt3}, 64'((i + 1 > 255) ? 255 : i + 1));
    end
    in_valid3 = 1'b0;

    for (int i = 24; i < 27; i++) step(tbl[i], i);
    #3;
    reset = 1'b1;
    #1;
    chk("async out_valid", {60'd0, out_valid}, 64'd0);
    chk("async rr_ptr", {62'd0, rr_ptr}, 64'd0);
    chk("async drop_cnt3", {56'd0, drop_cnt3}, 64'd0);
    chk("async out_data", out_data, 64'd0);
    for (int k = 0; k < 4; k++) sbq[k].delete();
    brr = 2'd0;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 27; i < 29; i++) step(tbl[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
